// File: rtl/sram_like_initiator.sv
// Bridges an SRAM-style upstream port onto a req/addr_ok/data_ok downstream bus, one transaction at a time.
// Optional macro SRAM_LIKE_SIZE_DECODE_EN derives the downstream size from the write strobes.
module sram_like_initiator #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          sram_en,
  input  logic [3:0]    sram_wen,
  input  logic [AW-1:0] sram_addr,
  input  logic [31:0]   sram_wdata,
  output logic [31:0]   sram_rdata,
  output logic          sram_stall,
  output logic          req,
  output logic          wr,
  output logic [3:0]    wstrb,
  output logic [AW-1:0] addr,
  output logic [2:0]    size,
  output logic [31:0]   wdata,
  input  logic [31:0]   rdata,
  input  logic          addr_ok,
  input  logic          data_ok,
  output logic          proto_err,
  output logic [1:0]    dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    wen_q, wen_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          perr_q, perr_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      wen_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      perr_q  <= perr_d;
    end
  end

  // Handshake: req is held with stable fields until addr_ok; the single
  // outstanding transaction then completes on data_ok. sram_stall tells the
  // upstream to hold sram_en and its qualifiers unchanged.
  always_comb begin
    state_d    = state_q;
    wen_d      = wen_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    perr_d     = perr_q;
    req        = 1'b0;
    sram_stall = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (sram_en) begin
          wen_d      = sram_wen;
          addr_d     = sram_addr;
          wdata_d    = sram_wdata;
          state_d    = ST_REQ;
          sram_stall = 1'b1;
        end
      end
      ST_REQ: begin
        req        = 1'b1;
        sram_stall = 1'b1;
        if (addr_ok) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (data_ok) begin
          if (wen_q == 4'b0000) rdata_d = rdata;
          state_d = ST_IDLE;
        end else begin
          sram_stall = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // data_ok is only legitimate while a transaction has been accepted.
    if (data_ok && state_q != ST_WAIT) perr_d = 1'b1;
  end

  assign wr          = (wen_q != 4'b0000);
  assign wstrb       = wen_q;
  assign addr        = addr_q;
  assign wdata       = wdata_q;
  assign sram_rdata  = rdata_q;
  assign proto_err   = perr_q;
  assign dbg_state_o = state_q;

`ifdef SRAM_LIKE_SIZE_DECODE_EN
  always_comb begin
    size = 3'd2;
    if (wen_q != 4'b0000) begin
      unique case (wen_q)
        4'b0001, 4'b0010, 4'b0100, 4'b1000: size = 3'd0;
        4'b0011, 4'b1100:                   size = 3'd1;
        default:                            size = 3'd2;
      endcase
    end
  end
`else
  assign size = 3'd2;
`endif

endmodule

// File: tb/tb_sram_like_initiator.sv
// Self-checking bench for sram_like_initiator: directed scenarios plus a random
// transaction loop, with expected read data tracked through a scoreboard queue.
module tb_sram_like_initiator;

  logic        clk = 1'b0;
  logic        resetn;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        sram_stall;
  logic        req;
  logic        wr;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [2:0]  size;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;
  logic        proto_err;
  logic [1:0]  dbg_state_o;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd;

  sram_like_initiator #(.AW(32)) dut (
    .clk(clk), .resetn(resetn), .sram_en(sram_en), .sram_wen(sram_wen),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_stall(sram_stall), .req(req), .wr(wr), .wstrb(wstrb), .addr(addr),
    .size(size), .wdata(wdata), .rdata(rdata), .addr_ok(addr_ok),
    .data_ok(data_ok), .proto_err(proto_err), .dbg_state_o(dbg_state_o)
  );

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_size(input logic [3:0] w);
`ifdef SRAM_LIKE_SIZE_DECODE_EN
    if (w == 4'b0000) return 3'd2;
    case (w)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: return 3'd0;
      4'b0011, 4'b1100:                   return 3'd1;
      default:                            return 3'd2;
    endcase
`else
    return 3'd2;
`endif
  endfunction

  // Driver: one full transaction, starting at a negedge with the FSM in IDLE.
  // Ends at the negedge after completion, leaving the upstream idle.
  task automatic txn(input logic [3:0] w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] rd, input int aok_dly, input int wait_cyc,
                     output int req_cyc);
    logic [31:0] er;
    sram_en = 1'b1; sram_wen = w; sram_addr = a; sram_wdata = wd;
    if (w == 4'b0000) exp_q.push_back(rd);
    #1 check("stall_idle_en", sram_stall, 1);
    @(negedge clk);
    req_cyc = cyc;
    for (int i = 0; i <= aok_dly; i++) begin
      check("req_high", req, 1);
      check("state_req", dbg_state_o, 1);
      check("stall_req", sram_stall, 1);
      check("wr", wr, (w != 4'b0000));
      check("wstrb", wstrb, w);
      check("addr", addr, a);
      check("wdata", wdata, wd);
      check("size", size, exp_size(w));
      if (i == aok_dly) addr_ok = 1'b1;
      @(negedge clk);
      addr_ok = 1'b0;
    end
    for (int j = 0; j < wait_cyc; j++) begin
      check("req_low_wait", req, 0);
      check("state_wait", dbg_state_o, 2);
      check("stall_wait", sram_stall, 1);
      @(negedge clk);
    end
    check("state_wait_dok", dbg_state_o, 2);
    data_ok = 1'b1; rdata = rd;
    sram_en = 1'b0; sram_wen = 4'b0000;
    #1 check("stall_drop_dok", sram_stall, 0);
    @(negedge clk);
    data_ok = 1'b0; rdata = $urandom;
    check("state_idle_done", dbg_state_o, 0);
    check("req_low_idle", req, 0);
    if (w == 4'b0000) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 1, 0);
      end else begin
        er = exp_q.pop_front();
        last_rd = er;
      end
    end
    check("sram_rdata", sram_rdata, last_rd);
    check("proto_err_clean", proto_err, 0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    @(negedge clk);
    check("rst_state", dbg_state_o, 0);
    check("rst_req", req, 0);
    check("rst_rdata", sram_rdata, 0);
    check("rst_perr", proto_err, 0);
    last_rd = 32'h0;
    resetn = 1'b1;
  endtask

  initial begin
    int c1, c2;
    logic [3:0] wen_tab [10];
    wen_tab = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
    resetn = 1'b0; sram_en = 1'b0; sram_wen = 4'h0; sram_addr = 32'h0;
    sram_wdata = 32'h0; rdata = 32'h0; addr_ok = 1'b0; data_ok = 1'b0;
    last_rd = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_state", dbg_state_o, 0);
    check("rst_req", req, 0);
    check("rst_stall", sram_stall, 0);
    check("rst_addr", addr, 0);
    check("rst_wstrb", wstrb, 0);
    check("rst_wdata", wdata, 0);
    check("rst_rdata", sram_rdata, 0);
    check("rst_perr", proto_err, 0);
    resetn = 1'b1;
    @(negedge clk);

    // Single read: addr_ok immediately, data_ok two cycles after addr_ok
    txn(4'h0, 32'h1000, 32'h0, 32'hDEADBEEF, 0, 1, c1);
    @(negedge clk);
    // Write with addr_ok delayed three cycles
    txn(4'b1100, 32'h2002, 32'h12340000, 32'h55555555, 3, 0, c1);
    // Back-to-back read then write, zero-wait downstream
    txn(4'h0, 32'h3000, 32'h0, 32'hA5A5F00D, 0, 0, c1);
    txn(4'b0001, 32'h3004, 32'h000000EE, 32'h0, 0, 0, c2);
    check("b2b_spacing", c2 - c1, 3);

    // Random transactions, random gaps and delays
    for (int k = 0; k < 20; k++) begin
      txn(wen_tab[$urandom_range(0, 9)], $urandom, $urandom, $urandom,
          $urandom_range(0, 3), $urandom_range(0, 3), c1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Stray data_ok in IDLE: sticky error, read data untouched
    data_ok = 1'b1; rdata = 32'hBADBAD00;
    @(negedge clk);
    data_ok = 1'b0;
    check("perr_idle", proto_err, 1);
    check("rdata_keep_idle", sram_rdata, last_rd);
    check("state_idle_perr", dbg_state_o, 0);
    repeat (2) @(negedge clk);
    check("perr_sticky", proto_err, 1);
    do_reset();
    @(negedge clk);

    // data_ok in REQ, then together with addr_ok
    sram_en = 1'b1; sram_wen = 4'h0; sram_addr = 32'h3000;
    @(negedge clk);
    data_ok = 1'b1; rdata = 32'h11111111;
    @(negedge clk);
    check("state_req_hold", dbg_state_o, 1);
    check("perr_req", proto_err, 1);
    check("rdata_ignored_req", sram_rdata, 0);
    addr_ok = 1'b1;
    @(negedge clk);
    addr_ok = 1'b0; data_ok = 1'b0; sram_en = 1'b0;
    check("state_adv_wait", dbg_state_o, 2);
    check("rdata_ignored_aok", sram_rdata, 0);
    data_ok = 1'b1; rdata = 32'hCAFEF00D;
    @(negedge clk);
    data_ok = 1'b0;
    check("state_idle_after", dbg_state_o, 0);
    check("rdata_after_viol", sram_rdata, 32'hCAFEF00D);
    do_reset();
    @(negedge clk);

    // Reset while in WAIT, late data_ok afterwards
    sram_en = 1'b1; sram_wen = 4'h0; sram_addr = 32'h4000;
    @(negedge clk);
    addr_ok = 1'b1;
    @(negedge clk);
    addr_ok = 1'b0; sram_en = 1'b0;
    check("state_wait_pre_rst", dbg_state_o, 2);
    do_reset();
    @(negedge clk);
    data_ok = 1'b1; rdata = 32'hDEAD0001;
    @(negedge clk);
    data_ok = 1'b0;
    check("late_dok_perr", proto_err, 1);
    check("late_dok_state", dbg_state_o, 0);
    check("late_dok_req", req, 0);
    check("late_dok_rdata", sram_rdata, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
